// File: rtl/bcd_to_d_scan.sv
// bcd_to_d_scan: scanned decoder from a latched signed 3-digit BCD word
// to one-hot decimal lines, cycling sign / hundreds / tens / units.
module bcd_to_d_scan #(
  parameter int DIV   = 4,     // cycles each position is held (>= 1)
  parameter bit BLANK = 1'b1   // 1 = blank leading zeros in hundreds/tens
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        ld_i,
  input  logic        sgn_i,
  input  logic [11:0] bcd_i,
  output logic [9:0]  dec_o,
  output logic [3:0]  sel_o,
  output logic        neg_o,
  output logic        err_o,
  output logic        frame_o
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [11:0]   h_q;
  logic          hs_q;
  logic [1:0]    pos_q;
  logic [DW-1:0] div_q;
  logic          err_q;
  logic          frame_q;

  logic          bad_nibble;
  logic          div_wrap;
  logic [3:0]    digit;
  logic          blank;

  assign bad_nibble = (bcd_i[11:8] > 4'd9) | (bcd_i[7:4] > 4'd9) | (bcd_i[3:0] > 4'd9);
  assign div_wrap   = (div_q == DIV_LAST);

  // Word capture, scan divider/position counter and frame pulse; load wins over scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q     <= 12'd0;
      hs_q    <= 1'b0;
      pos_q   <= 2'd0;
      div_q   <= '0;
      err_q   <= 1'b0;
      frame_q <= 1'b0;
    end else if (ld_i) begin
      h_q     <= bcd_i;
      hs_q    <= sgn_i;
      err_q   <= bad_nibble;
      pos_q   <= 2'd0;
      div_q   <= '0;
      frame_q <= 1'b0;
    end else if (en_i) begin
      if (div_wrap) begin
        div_q   <= '0;
        pos_q   <= pos_q + 2'd1;
        frame_q <= (pos_q == 2'd3);
      end else begin
        div_q   <= div_q + DW'(1);
        frame_q <= 1'b0;
      end
    end else begin
      frame_q <= 1'b0;
    end
  end

  // Pick the digit for the current position and decide whether it is a blanked leading zero.
  always_comb begin
    digit = 4'd0;
    blank = 1'b0;
    case (pos_q)
      2'd1: begin
        digit = h_q[11:8];
        blank = BLANK && (h_q[11:8] == 4'd0);
      end
      2'd2: begin
        digit = h_q[7:4];
        blank = BLANK && (h_q[11:8] == 4'd0) && (h_q[7:4] == 4'd0);
      end
      2'd3: begin
        digit = h_q[3:0];
      end
      default: begin
        digit = 4'd0;
        blank = 1'b0;
      end
    endcase
  end

  // One-hot digit line; sign position, blanked zeros and invalid nibbles show nothing.
  always_comb begin
    dec_o = 10'd0;
    if (en_i && (pos_q != 2'd0) && !blank && (digit <= 4'd9)) begin
      dec_o = 10'd1 << digit;
    end
  end

  assign sel_o   = en_i ? (4'b0001 << pos_q) : 4'b0000;
  // Negative zero is shown as positive.
  assign neg_o   = hs_q & (h_q != 12'd0);
  assign err_o   = err_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_bcd_to_d_scan.sv
// Directed bench for bcd_to_d_scan: a DIV=4/BLANK=1 instance plus a
// DIV=1/BLANK=0 instance sharing the same stimulus.
module tb_bcd_to_d_scan;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        ld;
  logic        sgn;
  logic [11:0] bcd;

  logic [9:0] dec_a, dec_b;
  logic [3:0] sel_a, sel_b;
  logic       neg_a, neg_b, err_a, err_b, frame_a, frame_b;

  int checks = 0;
  int failures = 0;

  bcd_to_d_scan #(.DIV(4), .BLANK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .ld_i(ld), .sgn_i(sgn), .bcd_i(bcd),
    .dec_o(dec_a), .sel_o(sel_a), .neg_o(neg_a), .err_o(err_a), .frame_o(frame_a)
  );

  bcd_to_d_scan #(.DIV(1), .BLANK(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en_i(en), .ld_i(ld), .sgn_i(sgn), .bcd_i(bcd),
    .dec_o(dec_b), .sel_o(sel_b), .neg_o(neg_b), .err_o(err_b), .frame_o(frame_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic s, input logic [11:0] v);
    sgn = s;
    bcd = v;
    ld  = 1'b1;
    step(1);
    ld  = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; ld = 1'b0; sgn = 1'b0; bcd = 12'h000;
    step(2);
    checks++; if (dec_a !== 10'd0) begin failures++; $display("FAIL reset_dec got=%b exp=%b", dec_a, 10'd0); end
    checks++; if (sel_a !== 4'd0) begin failures++; $display("FAIL reset_sel got=%b exp=%b", sel_a, 4'd0); end
    checks++; if ({neg_a, err_a, frame_a} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {neg_a, err_a, frame_a}); end
    en = 1'b1;
    #1;
    checks++; if (sel_a !== 4'b0001) begin failures++; $display("FAIL reset_sel_en got=%b exp=0001", sel_a); end
    checks++; if (dec_a !== 10'd0) begin failures++; $display("FAIL reset_dec_en got=%b exp=0", dec_a); end
  endtask

  task automatic test_idle_scan;
    logic [1:0] pa, pb;
    logic [9:0] ea, eb;
    rst_n = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      step(1);
      pa = 2'((c / 4) % 4);
      pb = 2'(c % 4);
      ea = (pa == 2'd3) ? 10'd1 : 10'd0;
      eb = (pb == 2'd0) ? 10'd0 : 10'd1;
      checks++; if (sel_a !== (4'b0001 << pa)) begin failures++; $display("FAIL idle_sel_a c=%0d got=%b exp=%b", c, sel_a, 4'b0001 << pa); end
      checks++; if (dec_a !== ea) begin failures++; $display("FAIL idle_dec_a c=%0d got=%b exp=%b", c, dec_a, ea); end
      checks++; if (frame_a !== (c % 16 == 0)) begin failures++; $display("FAIL idle_frame_a c=%0d got=%b exp=%b", c, frame_a, (c % 16 == 0)); end
      checks++; if (sel_b !== (4'b0001 << pb)) begin failures++; $display("FAIL idle_sel_b c=%0d got=%b exp=%b", c, sel_b, 4'b0001 << pb); end
      checks++; if (dec_b !== eb) begin failures++; $display("FAIL idle_dec_b c=%0d got=%b exp=%b", c, dec_b, eb); end
      checks++; if (frame_b !== (c % 4 == 0)) begin failures++; $display("FAIL idle_frame_b c=%0d got=%b exp=%b", c, frame_b, (c % 4 == 0)); end
      checks++; if ({neg_a, err_a} !== 2'b00) begin failures++; $display("FAIL idle_flags c=%0d got=%b exp=00", c, {neg_a, err_a}); end
    end
  endtask

  task automatic test_load_275;
    load(1'b1, 12'h275);
    checks++; if (sel_a !== 4'b0001) begin failures++; $display("FAIL l275_sel0 got=%b exp=0001", sel_a); end
    checks++; if (dec_a !== 10'd0) begin failures++; $display("FAIL l275_dec0 got=%b exp=0", dec_a); end
    checks++; if (neg_a !== 1'b1) begin failures++; $display("FAIL l275_neg got=%b exp=1", neg_a); end
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL l275_err got=%b exp=0", err_a); end
    step(4);
    checks++; if (dec_a !== 10'b0000000100) begin failures++; $display("FAIL l275_hund got=%b exp=0000000100", dec_a); end
    step(4);
    checks++; if (dec_a !== 10'b0010000000) begin failures++; $display("FAIL l275_tens got=%b exp=0010000000", dec_a); end
    step(4);
    checks++; if (dec_a !== 10'b0000100000) begin failures++; $display("FAIL l275_units got=%b exp=0000100000", dec_a); end
    checks++; if (sel_a !== 4'b1000) begin failures++; $display("FAIL l275_sel3 got=%b exp=1000", sel_a); end
  endtask

  task automatic test_blank_007;
    load(1'b0, 12'h007);
    checks++; if (neg_a !== 1'b0) begin failures++; $display("FAIL b007_neg got=%b exp=0", neg_a); end
    step(1);
    checks++; if (dec_b !== 10'b0000000001) begin failures++; $display("FAIL b007_b_hund got=%b exp=0000000001", dec_b); end
    step(1);
    checks++; if (dec_b !== 10'b0000000001) begin failures++; $display("FAIL b007_b_tens got=%b exp=0000000001", dec_b); end
    step(1);
    checks++; if (dec_b !== 10'b0010000000) begin failures++; $display("FAIL b007_b_units got=%b exp=0010000000", dec_b); end
    step(1);
    checks++; if ({sel_a, dec_a} !== {4'b0010, 10'd0}) begin failures++; $display("FAIL b007_a_hund got=%b/%b exp=0010/0", sel_a, dec_a); end
    step(4);
    checks++; if ({sel_a, dec_a} !== {4'b0100, 10'd0}) begin failures++; $display("FAIL b007_a_tens got=%b/%b exp=0100/0", sel_a, dec_a); end
    step(4);
    checks++; if (dec_a !== 10'b0010000000) begin failures++; $display("FAIL b007_a_units got=%b exp=0010000000", dec_a); end
  endtask

  task automatic test_neg_zero_err;
    load(1'b1, 12'h000);
    checks++; if (neg_a !== 1'b0) begin failures++; $display("FAIL negzero got=%b exp=0", neg_a); end
    load(1'b0, 12'h3A1);
    checks++; if (err_a !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", err_a); end
    step(4);
    checks++; if (dec_a !== 10'b0000001000) begin failures++; $display("FAIL err_hund got=%b exp=0000001000", dec_a); end
    step(4);
    checks++; if ({sel_a, dec_a} !== {4'b0100, 10'd0}) begin failures++; $display("FAIL err_tens got=%b/%b exp=0100/0", sel_a, dec_a); end
    checks++; if (err_a !== 1'b1) begin failures++; $display("FAIL err_hold got=%b exp=1", err_a); end
    load(1'b0, 12'h123);
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", err_a); end
  endtask

  task automatic test_en_freeze;
    load(1'b0, 12'h456);
    step(10);
    en = 1'b0;
    #1;
    checks++; if ({sel_a, dec_a} !== 14'd0) begin failures++; $display("FAIL frz_gate got=%b/%b exp=0/0", sel_a, dec_a); end
    for (int i = 0; i < 5; i++) begin
      step(1);
      checks++; if ({sel_a, dec_a, frame_a} !== 15'd0) begin failures++; $display("FAIL frz_hold i=%0d got=%b/%b/%b exp=0", i, sel_a, dec_a, frame_a); end
    end
    en = 1'b1;
    #1;
    checks++; if ({sel_a, dec_a} !== {4'b0100, 10'b0000100000}) begin failures++; $display("FAIL frz_resume got=%b/%b exp=0100/0000100000", sel_a, dec_a); end
    step(1);
    checks++; if (sel_a !== 4'b0100) begin failures++; $display("FAIL frz_div3 got=%b exp=0100", sel_a); end
    step(1);
    checks++; if ({sel_a, dec_a} !== {4'b1000, 10'b0001000000}) begin failures++; $display("FAIL frz_units got=%b/%b exp=1000/0001000000", sel_a, dec_a); end
    step(3);
    load(1'b0, 12'h456);
    checks++; if ({sel_a, frame_a} !== 5'b00010) begin failures++; $display("FAIL ld_restart got=%b/%b exp=0001/0", sel_a, frame_a); end
    for (int c = 1; c <= 16; c++) begin
      step(1);
      checks++; if (frame_a !== (c == 16)) begin failures++; $display("FAIL ld_frame c=%0d got=%b exp=%b", c, frame_a, (c == 16)); end
    end
  endtask

  task automatic test_async_reset;
    load(1'b1, 12'h9A9);
    step(6);
    checks++; if ({neg_a, err_a} !== 2'b11) begin failures++; $display("FAIL ar_pre got=%b exp=11", {neg_a, err_a}); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({neg_a, err_a, frame_a} !== 3'b000) begin failures++; $display("FAIL ar_flags got=%b exp=000", {neg_a, err_a, frame_a}); end
    checks++; if ({sel_a, dec_a} !== {4'b0001, 10'd0}) begin failures++; $display("FAIL ar_pos got=%b/%b exp=0001/0", sel_a, dec_a); end
    en = 1'b0;
    #1;
    checks++; if ({sel_a, dec_a} !== 14'd0) begin failures++; $display("FAIL ar_off got=%b/%b exp=0/0", sel_a, dec_a); end
    step(1);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_load_275();
    test_blank_007();
    test_neg_zero_err();
    test_en_freeze();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
